// File: rtl/shifter_ctl_stage.sv
// shifter_ctl_stage
//   Registered decode stage in front of the execute-stage barrel shifter.
//   It turns an ARM shifter-operand descriptor into the shifter's controls:
//   the one-hot rotate selects, the mask controls and the carry-out select.
//   For register-specified amounts it fetches Rs[7:0] through rs_req/rs_valid.
//   The result sits in an output register until the execute stage takes it.
//
// Ports
//   clk, reset (async, active-high), flush (sync kill)
//   in_valid/in_ready       descriptor handshake: sh_type, sh_reg, sh_imm, c_in
//   rs_req/rs_valid/rs_val  Rs fetch; rs_req is high in the accept cycle
//   out_valid/out_ready     control-word handshake
//   shamt, longshift        mask amount, saturated to 32
//   shctl_5, shctl_8        one-hot rotate selects (ROR 0..4, ROR 0,4,..,28)
//   left, shift, arith      mask direction / mask enable / sign fill
//   rrx, c_q                rotate-in select for RRX / registered carry-in
//   cout_sel                0 c_q, 1 a0, 2 a31, 3 rot0, 4 rot31, 5 zero
module shifter_ctl_stage (
  input  logic       clk,
  input  logic       reset,
  input  logic       flush,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [1:0] sh_type,
  input  logic       sh_reg,
  input  logic [4:0] sh_imm,
  input  logic       c_in,
  output logic       rs_req,
  input  logic       rs_valid,
  input  logic [7:0] rs_val,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [4:0] shamt,
  output logic       longshift,
  output logic [4:0] shctl_5,
  output logic [7:0] shctl_8,
  output logic       left,
  output logic       shift,
  output logic       arith,
  output logic       rrx,
  output logic       c_q,
  output logic [2:0] cout_sel
);

  typedef enum logic {IDLE, RS_WAIT} state_e;
  typedef enum logic [1:0] {T_LSL, T_LSR, T_ASR, T_ROR} sh_type_e;
  typedef enum logic [2:0] {
    CS_CQ, CS_A0, CS_A31, CS_ROT0, CS_ROT31, CS_ZERO
  } cout_e;

  state_e   state, state_nx;
  sh_type_e pend_type;
  logic     pend_c;
  logic     load_imm, load_reg, load;

  sh_type_e dec_type;
  logic     dec_reg, dec_c;
  logic [7:0] dec_n;
  logic [4:0] n5;
  logic       ge32, is32, imm0, reg0;

  logic [2:0] i5, i8;
  logic [4:0] d_shamt;
  logic       d_long, d_left, d_shift, d_arith, d_rrx;
  cout_e      d_cout;

  // Handshake and next-state
  always_comb begin
    state_nx = state;
    in_ready = 1'b0;
    rs_req   = 1'b0;
    load_imm = 1'b0;
    load_reg = 1'b0;
    case (state)
      IDLE: begin
        in_ready = (!out_valid || out_ready) && !flush;
        if (in_valid && in_ready) begin
          if (sh_reg) begin
            rs_req   = 1'b1;
            state_nx = RS_WAIT;
          end else begin
            load_imm = 1'b1;
          end
        end
      end
      RS_WAIT: begin
        if (rs_valid && !flush) begin
          load_reg = 1'b1;
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
    if (flush) state_nx = IDLE;
  end

  assign load = load_imm || load_reg;

  // The decoder serves both paths: in RS_WAIT it sees the latched type/carry
  // and the fetched Rs byte, otherwise the live immediate descriptor.
  assign dec_reg  = (state == RS_WAIT);
  assign dec_type = dec_reg ? pend_type : sh_type_e'(sh_type);
  assign dec_n    = dec_reg ? rs_val : {3'b000, sh_imm};
  assign dec_c    = dec_reg ? pend_c : c_in;
  assign n5       = dec_n[4:0];
  assign ge32     = dec_reg && (dec_n >= 8'd32);
  assign is32     = (dec_n == 8'd32);
  assign imm0     = !dec_reg && (n5 == 5'd0);
  assign reg0     = dec_reg && (dec_n == 8'd0);

  always_comb begin
    i5      = '0;
    i8      = '0;
    d_shamt = '0;
    d_long  = 1'b0;
    d_left  = 1'b0;
    d_shift = 1'b0;
    d_arith = 1'b0;
    d_rrx   = 1'b0;
    d_cout  = CS_CQ;
    case (dec_type)
      T_LSL: begin
        d_left  = 1'b1;
        d_shift = 1'b1;
        // Left shift by n is a right rotate by 32-n
        if (n5 != 5'd0) begin
          i5 = {1'b0, ~n5[1:0]} + 3'd1;
          i8 = ~n5[4:2];
        end
        if (ge32) begin
          d_long = 1'b1;
          d_cout = is32 ? CS_A0 : CS_ZERO;
        end else begin
          d_shamt = n5;
          d_cout  = (n5 == 5'd0) ? CS_CQ : CS_ROT0;
        end
      end
      T_LSR, T_ASR: begin
        d_shift = 1'b1;
        d_arith = (dec_type == T_ASR);
        i5      = {1'b0, n5[1:0]};
        i8      = n5[4:2];
        // Immediate #0 encodes a shift by 32
        if (ge32 || imm0) begin
          d_long = 1'b1;
          if (dec_type == T_LSR && ge32 && !is32) d_cout = CS_ZERO;
          else                                    d_cout = CS_A31;
        end else begin
          d_shamt = n5;
          d_cout  = CS_ROT31;
        end
      end
      default: begin
        if (imm0) begin
          i5     = 3'd1;
          d_rrx  = 1'b1;
          d_cout = CS_A0;
        end else if (dec_reg && n5 == 5'd0) begin
          d_cout = CS_A31;
        end else begin
          i5     = {1'b0, n5[1:0]};
          i8     = n5[4:2];
          d_cout = CS_ROT31;
        end
      end
    endcase
    // A zero register amount leaves the operand and carry untouched
    if (reg0) begin
      i5      = '0;
      i8      = '0;
      d_shamt = '0;
      d_long  = 1'b0;
      d_shift = 1'b0;
      d_rrx   = 1'b0;
      d_cout  = CS_CQ;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      pend_type <= T_LSL;
      pend_c    <= 1'b0;
      out_valid <= 1'b0;
      shctl_5   <= 5'b00001;
      shctl_8   <= 8'b00000001;
      shamt     <= '0;
      longshift <= 1'b0;
      left      <= 1'b0;
      shift     <= 1'b0;
      arith     <= 1'b0;
      rrx       <= 1'b0;
      c_q       <= 1'b0;
      cout_sel  <= '0;
    end else begin
      state <= state_nx;
      if (rs_req) begin
        pend_type <= sh_type_e'(sh_type);
        pend_c    <= c_in;
      end
      if (flush)          out_valid <= 1'b0;
      else if (load)      out_valid <= 1'b1;
      else if (out_ready) out_valid <= 1'b0;
      if (load) begin
        shctl_5   <= 5'b00001 << i5;
        shctl_8   <= 8'b00000001 << i8;
        shamt     <= d_shamt;
        longshift <= d_long;
        left      <= d_left;
        shift     <= d_shift;
        arith     <= d_arith;
        rrx       <= d_rrx;
        c_q       <= dec_c;
        cout_sel  <= d_cout;
      end
    end
  end

endmodule

// File: doc/shifter_ctl_stage.md
# shifter_ctl_stage

Registered decode stage directly upstream of the execute-stage barrel shifter. It accepts an ARM shifter-operand descriptor (type, immediate or register amount, carry-in) over a valid/ready handshake and converts it into the shifter's one-hot rotate selects, mask controls and carry-out selection. For register-specified shifts it fetches the amount from Rs over a request/response port. Outputs are held in a pipeline register until the execute stage accepts them.

## Interface
- No parameters; all widths fixed by the 32-bit datapath.
- clk  in  1  clock, all state on rising edge
- reset  in  1  asynchronous, active-high; clears all state
- flush  in  1  synchronous; kills the held and in-flight operations
- in_valid  in  1  descriptor present
- in_ready  out  1  stage accepts descriptor this cycle
- sh_type  in  2  00 LSL, 01 LSR, 10 ASR, 11 ROR
- sh_reg  in  1  1 = amount from Rs[7:0], 0 = amount from sh_imm
- sh_imm  in  5  immediate amount
- c_in  in  1  current C flag
- rs_req  out  1  one-cycle pulse requesting Rs
- rs_valid  in  1  rs_val valid (≥1 cycle after rs_req)
- rs_val  in  8  Rs[7:0]
- out_valid  out  1  control word held
- out_ready  in  1  execute stage consumes word
- shamt  out  5  mask amount low bits
- longshift  out  1  mask amount ≥32
- shctl_5  out  5  one-hot first-stage rotate select (ROR 0..4)
- shctl_8  out  8  one-hot second-stage select (ROR 0,4,…,28)
- left, shift, arith  out  1 each  mask direction / mask enable / sign fill
- rrx  out  1  1 = shifter takes c_q as rotate-in bit, else a[0]
- c_q  out  1  registered c_in
- cout_sel  out  3  0 c_q, 1 a0, 2 a31, 3 rot0, 4 rot31, 5 zero

## Operation
- FSM: IDLE, RS_WAIT. in_ready = (state==IDLE) && (!out_valid || out_ready).
- IDLE, accept with sh_reg=0: decode with n=sh_imm, load output register, out_valid=1.
- IDLE, accept with sh_reg=1: latch type and c_in, rs_req=1 that cycle, go RS_WAIT.
- RS_WAIT: on rs_valid, decode with n=rs_val, load output, out_valid=1, go IDLE. The output register is guaranteed free on entry to RS_WAIT.
- out_valid clears when out_ready && !new load.
- Rotate amount r (0..32) splits as r = i5 + 4*i8, with i5 in 0..4 and i8 in 0..7; shctl_5 = onehot(i5), shctl_8 = onehot(i8).
- Right ops: i5 = n[1:0], i8 = n[4:2].
- LSL with n[4:0]≠0: i5 = (~n[1:0])+1, i8 = ~n[4:2], giving rotate 32−n.
- {longshift,shamt} = min(n,32) for masked ops; for ROR, shift=0.
- left=1 only for LSL. shift=1 for LSL/LSR/ASR. arith=1 only for ASR.
- Immediate rules:
  - LSL#0: identity, cout c_q.
  - LSL#n: cout rot0.
  - LSR#0 means LSR#32: longshift=1, rotate 0, cout a31.
  - LSR#n: cout rot31.
  - ASR#0 means ASR#32: cout a31.
  - ASR#n: cout rot31.
  - ROR#0 means RRX: i5=1, i8=0, rrx=1, cout a0.
  - ROR#n: cout rot31.
- Register rules, with n = rs_val:
  - n=0: identity for all types, shift=0, cout c_q.
  - LSL 1–31: cout rot0. LSL 32: longshift, cout a0. LSL >32: longshift, cout zero.
  - LSR 1–31: cout rot31. LSR 32: cout a31. LSR >32: cout zero.
  - ASR ≥32: longshift, cout a31.
  - ROR with n[4:0]=0 and n≠0: identity, cout a31. Otherwise ROR uses n[4:0], cout rot31.
- rrx=0 except immediate ROR#0.
- flush: out_valid←0, state←IDLE. A late rs_valid is ignored; in_ready is forced 0 that cycle.

## Timing
- Reset values:
  - state=IDLE, out_valid=0, rs_req=0, rrx=0, c_q=0.
  - shctl_5=5'b00001, shctl_8=8'b00000001, so the shifter select stays one-hot.
  - shamt=0, longshift=0, left=0, shift=0, arith=0, cout_sel=0.
- Latency:
  - Immediate: 1 cycle from accept to out_valid.
  - Register: 1 cycle after the rs_valid cycle.
- Back-to-back immediate ops are sustained at 1/cycle when out_ready=1.
- Control outputs are stable while out_valid && !out_ready.

## Test plan
- Immediate LSL#5: shctl_5=5'b01000 (i5=3), shctl_8=8'b01000000 (i8=6), shamt=5, left=1, shift=1, cout_sel=3; out_valid the cycle after accept.
- Immediate LSR#0, ASR#0, ROR#0:
  - LSR#0: longshift=1, shamt=0, cout_sel=2.
  - ASR#0: arith=1.
  - ROR#0: rrx=1, shctl_5=5'b00010, cout_sel=1.
- Register LSL with rs_val=32, 33, 0 after 3-cycle rs_valid delay:
  - 32: longshift=1, cout_sel=1.
  - 33: longshift=1, cout_sel=5.
  - 0: shift=0, cout_sel=0.
  - In each case rs_req is a single pulse and in_ready=0 during the wait.
- Backpressure: out_ready=0 for 4 cycles with a second op pending → in_ready=0 and outputs frozen; second op is accepted in the cycle out_ready rises.
- Flush in RS_WAIT, then rs_valid next cycle → no out_valid, state IDLE, next immediate op decodes normally.
- Async reset asserted mid-RS_WAIT → all outputs immediately at reset values, without waiting for a clock edge.
